ncl_wavefront_ctrl: RTL and testbench
=====================================

NCL_WAVEFRONT_CTRL -- requirements
Module: ncl_wavefront_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits for the NCL multiplier datapath.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, watchdog limit in clk cycles; used only with NCL_WDOG_EN.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  controller accepts operands this cycle.
REQ-008 in_a, in_b  input  WIDTH each  single-rail operands.
REQ-009 dr_a, dr_b  output  WIDTH x dual_rail_logic  dual-rail operands to the NCL datapath.
REQ-010 dr_z  input  2*WIDTH x dual_rail_logic  dual-rail datapath result, asynchronous to clk.
REQ-011 out_valid  output  1  decoded result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_z  output  2*WIDTH  single-rail product.
REQ-014 err  output  1  sticky fault flag.

Function
REQ-015 Transfers SHALL occur only on cycles where valid and ready are both high.
REQ-016 States SHALL be IDLE, DATA, WAIT_DATA, NULL, WAIT_NULL, DONE, ERR.
REQ-017 IDLE: in_ready=1; dr_a and dr_b all-NULL (both rails 0); on input transfer, latch in_a/in_b and go to DATA.
REQ-018 DATA: drive the latched bits as dual-rail (bit 1 -> rail1=1, bit 0 -> rail0=1) for one cycle, then go to WAIT_DATA; dr_a/dr_b hold the DATA encoding through WAIT_DATA.
REQ-019 Completion SHALL be computed per result bit: complete = rail0 XOR rail1; null = neither rail set; illegal = both rails set.
REQ-020 The all-complete, all-null and any-illegal flags SHALL each pass through a 2-flop synchronizer before the FSM uses them.
REQ-021 WAIT_DATA: when the synchronized all-complete flag is seen high on 2 consecutive cycles, capture decoded dr_z (bit = rail1) into out_z and go to NULL.
REQ-022 NULL: drive dr_a/dr_b all-NULL, then go to WAIT_NULL.
REQ-023 WAIT_NULL: when the synchronized all-null flag is seen high on 2 consecutive cycles, go to DONE.
REQ-024 DONE: out_valid=1 with out_z stable; on output transfer go to IDLE.
REQ-025 in_ready SHALL be 0 in every state other than IDLE, so no new operand is accepted until the prior result has been consumed.
REQ-026 If the synchronized illegal flag is high in any state: set err=1, drive dr_a/dr_b all-NULL, and go to ERR; ERR holds until reset.
REQ-027 Minimum accept-to-out_valid latency SHALL be 10 cycles for an ideal zero-delay datapath.
REQ-028 out_z SHALL hold its last captured value until the next capture.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE; in_ready=0 while reset is asserted; out_valid=0; out_z=0; err=0; dr_a/dr_b all-NULL; synchronizers and counters cleared.
REQ-030 Reset asserted mid-operation SHALL abandon the transaction, with no out_valid pulse.

Configuration
REQ-031 With NCL_WDOG_EN defined: a counter runs in WAIT_DATA and WAIT_NULL, and reaching TIMEOUT_CYC sets err=1 and enters ERR; the counter clears on every state entry.
REQ-032 Without NCL_WDOG_EN: no counter logic exists, and the wait states wait indefinitely.

Structure
REQ-033 A shared package ncl_pkg SHALL hold the dual_rail_logic typedef (rail1, rail0), the state enum, and the NULL/DATA encode and decode functions.
REQ-034 A sub-module ncl_completion_detect SHALL be parameterized by width and output the raw all-complete, all-null and any-illegal flags.

Verification
REQ-035 Reset, then in_a=3, in_b=5, with the datapath model returning 15 after 3 cycles -> out_z=6'd15, out_valid high, err=0.
REQ-036 in_a=7, in_b=7 -> out_z=6'd49; in_ready low from accept until out_valid is consumed.
REQ-037 out_ready held low for 5 cycles in DONE -> out_valid and out_z=15 stable for 5 cycles, and no new in_valid is accepted.
REQ-038 Datapath drives bit 2 with both rails high -> err=1 within 4 cycles, state ERR, dr_a/dr_b NULL, err sticky until rst_n.
REQ-039 rst_n pulsed low during WAIT_DATA -> all outputs return to reset values immediately, with no out_valid pulse.
REQ-040 With NCL_WDOG_EN and TIMEOUT_CYC=8, dr_z held NULL after DATA -> err=1 after 8 cycles in WAIT_DATA.

Source files
------------

// File: rtl/ncl_pkg.sv
// Shared types and helpers for the NCL wavefront controller.
// Dual-rail encoding: {rail1, rail0}; 00 = NULL, 10 = one, 01 = zero.
package ncl_pkg;

  typedef struct packed {
    logic rail1;
    logic rail0;
  } dual_rail_logic;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT_DATA,
    S_NULL,
    S_WAIT_NULL,
    S_DONE,
    S_ERR
  } state_e;

  localparam dual_rail_logic DR_NULL = '{rail1: 1'b0, rail0: 1'b0};

  function automatic dual_rail_logic dr_encode(input logic b);
    return '{rail1: b, rail0: ~b};
  endfunction

  function automatic logic dr_decode(input dual_rail_logic d);
    return d.rail1;
  endfunction

endpackage

// File: rtl/ncl_completion_detect.sv
// Raw completion flags over a dual-rail bus.
// Flags are asynchronous; the consumer must synchronize them.
module ncl_completion_detect
  import ncl_pkg::*;
#(
  parameter int W = 6
) (
  input  dual_rail_logic [W-1:0] dr_i,
  output logic                   all_complete_o,
  output logic                   all_null_o,
  output logic                   any_illegal_o
);

  // Reduce per-bit complete/null/illegal into bus-wide flags
  always_comb begin
    all_complete_o = 1'b1;
    all_null_o     = 1'b1;
    any_illegal_o  = 1'b0;
    for (int i = 0; i < W; i++) begin
      all_complete_o = all_complete_o
                     & (dr_i[i].rail1 ^ dr_i[i].rail0);
      all_null_o     = all_null_o
                     & ~(dr_i[i].rail1 | dr_i[i].rail0);
      any_illegal_o  = any_illegal_o
                     | (dr_i[i].rail1 & dr_i[i].rail0);
    end
  end

endmodule

// File: rtl/ncl_wavefront_ctrl.sv
// Clocked controller sequencing DATA/NULL wavefronts through an NCL datapath.
// Optional watchdog on the wait states: define NCL_WDOG_EN.
module ncl_wavefront_ctrl
  import ncl_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic           [WIDTH-1:0]     in_a,
  input  logic           [WIDTH-1:0]     in_b,
  output dual_rail_logic [WIDTH-1:0]     dr_a,
  output dual_rail_logic [WIDTH-1:0]     dr_b,
  input  dual_rail_logic [2*WIDTH-1:0]   dr_z,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic           [2*WIDTH-1:0]   out_z,
  output logic                           err
);

  localparam int ZW = 2 * WIDTH;

  if (TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [ZW-1:0]    z_q, z_d;

  dual_rail_logic [WIDTH-1:0] dra_q, dra_d;
  dual_rail_logic [WIDTH-1:0] drb_q, drb_d;

  logic rdy_q, rdy_d;
  logic err_q, err_d;
  logic seen_q, seen_d;

  logic [1:0] cmp_sq, nul_sq, ill_sq;
  logic cmp_raw, nul_raw, ill_raw;
  logic cmp_s, nul_s, ill_s;

  logic in_fire, out_fire;
  logic wait_hit, wd_exp;

  ncl_completion_detect #(
    .W (ZW)
  ) u_cd (
    .dr_i           (dr_z),
    .all_complete_o (cmp_raw),
    .all_null_o     (nul_raw),
    .any_illegal_o  (ill_raw)
  );

  assign cmp_s = cmp_sq[1];
  assign nul_s = nul_sq[1];
  assign ill_s = ill_sq[1];

  assign in_fire  = in_valid & rdy_q;
  assign out_fire = out_valid & out_ready;

  assign wait_hit = ((state_q == S_WAIT_DATA) & cmp_s)
                  | ((state_q == S_WAIT_NULL) & nul_s);

`ifdef NCL_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            in_wait;

  assign in_wait = (state_q == S_WAIT_DATA)
                 | (state_q == S_WAIT_NULL);
  assign wd_exp  = in_wait
                 & (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Count cycles parked in a wait state; any state change restarts it
  always_comb begin
    wd_d = '0;
    if (in_wait && state_d == state_q) wd_d = wd_q + 1'b1;
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign wd_exp = 1'b0;
`endif

  // Two-flop synchronizers for the asynchronous datapath flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_sq <= '0;
      nul_sq <= '0;
      ill_sq <= '0;
    end else begin
      cmp_sq <= {cmp_sq[0], cmp_raw};
      nul_sq <= {nul_sq[0], nul_raw};
      ill_sq <= {ill_sq[0], ill_raw};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an illegal codeword overrides everything
  always_comb begin
    state_d = state_q;
    if (ill_s) begin
      state_d = S_ERR;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (in_fire) state_d = S_DATA;
        S_DATA:
          state_d = S_WAIT_DATA;
        S_WAIT_DATA:
          if (seen_q && cmp_s) state_d = S_NULL;
          else if (wd_exp)     state_d = S_ERR;
        S_NULL:
          state_d = S_WAIT_NULL;
        S_WAIT_NULL:
          if (seen_q && nul_s) state_d = S_DONE;
          else if (wd_exp)     state_d = S_ERR;
        S_DONE:
          if (out_fire) state_d = S_IDLE;
        S_ERR:
          state_d = S_ERR;
        default:
          state_d = S_ERR;
      endcase
    end
  end

  // Output/next-register values; dual-rail drive is registered
  // so the asynchronous datapath never sees FSM decode glitches
  always_comb begin
    dra_d = '0;
    drb_d = '0;
    if ((state_q == S_DATA || state_q == S_WAIT_DATA)
        && state_d != S_ERR) begin
      for (int i = 0; i < WIDTH; i++) begin
        dra_d[i] = dr_encode(a_q[i]);
        drb_d[i] = dr_encode(b_q[i]);
      end
    end
    z_d = z_q;
    if (state_q == S_WAIT_DATA && state_d == S_NULL) begin
      for (int i = 0; i < ZW; i++) z_d[i] = dr_decode(dr_z[i]);
    end
    seen_d = (state_d == state_q) & wait_hit;
    rdy_d  = (state_d == S_IDLE);
    err_d  = err_q | (state_d == S_ERR);
  end

  // Operand latch, result capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      z_q    <= '0;
      dra_q  <= '0;
      drb_q  <= '0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      if (in_fire) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      z_q    <= z_d;
      dra_q  <= dra_d;
      drb_q  <= drb_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
      seen_q <= seen_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q == S_DONE);
  assign out_z     = z_q;
  assign err       = err_q;
  assign dr_a      = dra_q;
  assign dr_b      = drb_q;

endmodule

// File: tb/tb_ncl_wavefront_ctrl.sv
// Bench for ncl_wavefront_ctrl with a behavioural NCL multiplier model.
// Build with NCL_WDOG_EN defined to also exercise the watchdog.
`timescale 1ns/1ps
module tb_ncl_wavefront_ctrl;
  import ncl_pkg::*;

  localparam int W  = 3;
  localparam int ZW = 2 * W;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, err;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [ZW-1:0] out_z;

  dual_rail_logic [W-1:0]  dr_a, dr_b;
  dual_rail_logic [ZW-1:0] dr_z, dz_q, tgt;

  int dp_delay = 0;
  int dp_cnt;
  bit dp_fault = 1'b0;
  bit dp_hold_null = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ncl_wavefront_ctrl #(
    .WIDTH       (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .dr_a      (dr_a),
    .dr_b      (dr_b),
    .dr_z      (dr_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .err       (err)
  );

  function automatic bit op_is_data(input dual_rail_logic [W-1:0] v);
    for (int i = 0; i < W; i++)
      if (v[i].rail1 == v[i].rail0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit op_is_null(input dual_rail_logic [W-1:0] v);
    for (int i = 0; i < W; i++)
      if (v[i].rail1 || v[i].rail0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int op_val(input dual_rail_logic [W-1:0] v);
    int r = 0;
    for (int i = 0; i < W; i++)
      if (v[i].rail1) r += (1 << i);
    return r;
  endfunction

  function automatic dual_rail_logic [ZW-1:0] enc_z(input int p);
    dual_rail_logic [ZW-1:0] r;
    for (int i = 0; i < ZW; i++) begin
      r[i].rail1 = p[i];
      r[i].rail0 = ~p[i];
    end
    return r;
  endfunction

  // Datapath model: product of the operands once both are complete
  always_comb begin
    tgt = dz_q;
    if (op_is_data(dr_a) && op_is_data(dr_b) && !dp_hold_null)
      tgt = enc_z(op_val(dr_a) * op_val(dr_b));
    else if (op_is_null(dr_a) && op_is_null(dr_b))
      tgt = '0;
  end

  // Datapath model: result appears dp_delay cycles after the inputs change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_q   <= '0;
      dp_cnt <= 0;
    end else if (tgt != dz_q) begin
      if (dp_cnt + 1 >= dp_delay) begin
        dz_q   <= tgt;
        dp_cnt <= 0;
      end else begin
        dp_cnt <= dp_cnt + 1;
      end
    end else begin
      dp_cnt <= 0;
    end
  end

  // Zero-delay pass-through plus bit-2 double-rail fault injection
  always_comb begin
    dr_z = (dp_delay == 0) ? tgt : dz_q;
    if (dp_fault) dr_z[2] = '{rail1: 1'b1, rail0: 1'b1};
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_accept", in_ready, 1);
  endtask

  // One full transaction; expected timing is 10 cycles plus the
  // model delay on each of the DATA and NULL wavefronts
  task automatic do_txn(input int a, input int b,
                        input int d, input int stall);
    int lat;
    int busy_rdy;
    logic [ZW-1:0] exp;
    exp = ZW'(a * b);
    dp_delay = d;
    wait_ready();
    in_a = W'(a);
    in_b = W'(b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    busy_rdy = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_rdy++;
      tick();
      lat++;
    end
    check("ready_low_busy", busy_rdy, 0);
    check("latency", lat, 10 + 2 * d);
    check("out_valid", out_valid, 1);
    check("out_z", out_z, exp);
    check("err_clear", err, 0);
    in_valid = 1'b1;
    in_a = W'($urandom_range(0, 7));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_z", out_z, exp);
      check("stall_no_accept", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("z_hold", out_z, exp);
    check("ready_back", in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_z"}, out_z, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_dr_a"}, dr_a, 0);
    check({tag, "_dr_b"}, dr_b, 0);
  endtask

  initial begin
    int n;
    int pulses;

    // reset values
    #1;
    check_reset_outputs("rst");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", in_ready, 1);

    // directed products
    do_txn(3, 5, 3, 0);
    do_txn(7, 7, 0, 0);
    do_txn(3, 5, 1, 5);
    do_txn(0, 6, 2, 1);
    do_txn(7, 1, 0, 2);

    // randomized products, delays and consumer stalls
    for (int k = 0; k < 16; k++) begin
      do_txn($urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // illegal codeword on result bit 2
    dp_delay = 2;
    wait_ready();
    in_a = 3'd6;
    in_b = 3'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    dp_fault = 1'b1;
    n = 0;
    while (!err && n < 10) begin
      tick();
      n++;
    end
    check("err_set", err, 1);
    check("err_within_4", n <= 4, 1);
    tick();
    check("err_dr_a_null", dr_a, 0);
    check("err_dr_b_null", dr_b, 0);
    check("err_no_ready", in_ready, 0);
    dp_fault = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || !err || in_ready) pulses++;
    end
    check("err_sticky", pulses, 0);
    rst_n = 1'b0;
    #1;
    check("err_cleared", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // reset pulse while waiting for DATA
    dp_delay = 3;
    wait_ready();
    in_a = 3'd4;
    in_b = 3'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("midrst_no_valid", pulses, 0);
    do_txn(5, 6, 1, 0);

`ifdef NCL_WDOG_EN
    // watchdog: datapath never produces DATA
    dp_delay = 0;
    dp_hold_null = 1'b1;
    wait_ready();
    in_a = 3'd2;
    in_b = 3'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    check("wdog_err", err, 1);
    check("wdog_cycles", n, 1 + TO);
    check("wdog_dr_null", dr_a, 0);
    dp_hold_null = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
